// File: rtl/tinyalu_pkg.sv
// Shared TinyALU types: opcodes, driver FSM states, LFSR seed and the request record.
package tinyalu_pkg;

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_ADD = 3'b001,
        OP_AND = 3'b010,
        OP_XOR = 3'b011,
        OP_MUL = 3'b100
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } drv_state_e;

    localparam logic [7:0] LFSR_SEED  = 8'hA5;
    localparam int         ALU_DATA_W = 8;
    localparam int         ALU_TAG_W  = 4;

    // Default-width request record; op stays raw so reserved codes pass through untouched.
    typedef struct packed {
        logic [2:0]            op;
        logic [ALU_DATA_W-1:0] a;
        logic [ALU_DATA_W-1:0] b;
        logic [ALU_TAG_W-1:0]  tag;
    } alu_req_s;

    // Fibonacci LFSR, taps 8,6,5,4.
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

endpackage

// File: rtl/alu_req_driver_if.sv
// Request, ALU and response signals of alu_req_driver; master = driver side, slave = environment side.
interface alu_req_driver_if #(
    parameter int DATA_W = 8,
    parameter int TAG_W  = 4,
    parameter int DEPTH  = 4
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic                the_unused_guard;
    logic                req_valid;
    logic                req_ready;
    logic [2:0]          req_op;
    logic [DATA_W-1:0]   req_a;
    logic [DATA_W-1:0]   req_b;
    logic [TAG_W-1:0]    req_tag;
    logic [1:0]          gap_cfg;
    logic                start;
    logic [2:0]          op;
    logic [DATA_W-1:0]   A;
    logic [DATA_W-1:0]   B;
    logic                done;
    logic [2*DATA_W-1:0] result;
    logic                rsp_valid;
    logic [TAG_W-1:0]    rsp_tag;
    logic [2*DATA_W-1:0] rsp_result;
    logic                rsp_err;
    logic                busy;
    logic [LVL_W-1:0]    fifo_level;

    modport master (
        input  req_valid, req_op, req_a, req_b, req_tag, gap_cfg, done, result,
        output req_ready, start, op, A, B, rsp_valid, rsp_tag, rsp_result, rsp_err,
               busy, fifo_level
    );

    modport slave (
        output req_valid, req_op, req_a, req_b, req_tag, gap_cfg, done, result,
        input  req_ready, start, op, A, B, rsp_valid, rsp_tag, rsp_result, rsp_err,
               busy, fifo_level
    );

endinterface

// File: rtl/alu_req_fifo.sv
// Synchronous FIFO with combinational head read; push while full and pop while empty are dropped.
module alu_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push_ok, pop_ok;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign level   = level_q;

    // Pointers are exactly log2(DEPTH) bits, so increment wraps modulo DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/alu_req_driver.sv
// Queued, tagged request front-end for the start/done ALU with post-op gap and done-timeout.
// Build macro ALU_REQ_DRV_LFSR_GAP_EN: gap length taken from an LFSR instead of gap_cfg.
module alu_req_driver #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 64
) (
    input logic              clk,
    input logic              reset_n,
    alu_req_driver_if.master bus
);
    import tinyalu_pkg::*;

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam int RW = 2 * DATA_W;

    typedef struct packed {
        logic [2:0]        op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [TAG_W-1:0]  tag;
    } req_t;

    req_t          wr_req, head;
    logic          push, pop, fifo_full, fifo_empty;
    logic [LW-1:0] level;
    logic [1:0]    gap_sel;

    drv_state_e        state_q, state_d;
    logic              start_q, start_d;
    logic [2:0]        op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [1:0]        gap_q, gap_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
    logic [RW-1:0]     rsp_result_q, rsp_result_d;
    logic              rsp_err_q, rsp_err_d;

    assign wr_req = '{op: bus.req_op, a: bus.req_a, b: bus.req_b, tag: bus.req_tag};
    assign push   = bus.req_valid && !fifo_full;

    alu_req_fifo #(.WIDTH($bits(req_t)), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .wdata   (wr_req),
        .pop     (pop),
        .rdata   (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

`ifdef ALU_REQ_DRV_LFSR_GAP_EN
    logic [7:0] lfsr_q, lfsr_d;
    logic       unused_gap_cfg;

    assign lfsr_d         = lfsr_next(lfsr_q);
    assign gap_sel        = lfsr_q[1:0];
    assign unused_gap_cfg = ^bus.gap_cfg;

    always_ff @(posedge clk) begin
        if (!reset_n) lfsr_q <= LFSR_SEED;
        else          lfsr_q <= lfsr_d;
    end
`else
    assign gap_sel = bus.gap_cfg;
`endif

    always_comb begin
        state_d      = state_q;
        start_d      = start_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        tag_d        = tag_q;
        tmo_d        = tmo_q;
        gap_d        = gap_q;
        rsp_valid_d  = 1'b0;
        rsp_tag_d    = rsp_tag_q;
        rsp_result_d = rsp_result_q;
        rsp_err_d    = rsp_err_q;
        pop          = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    op_d    = head.op;
                    a_d     = head.a;
                    b_d     = head.b;
                    tag_d   = head.tag;
                    start_d = 1'b1;
                    tmo_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // done is checked first so it wins over a same-cycle timeout.
                if (op_q == OP_NOP || bus.done) begin
                    start_d      = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_tag_d    = tag_q;
                    rsp_result_d = (op_q == OP_NOP) ? '0 : bus.result;
                    rsp_err_d    = 1'b0;
                    gap_d        = gap_sel;
                    state_d      = GAP;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    start_d      = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_tag_d    = tag_q;
                    rsp_result_d = '0;
                    rsp_err_d    = 1'b1;
                    gap_d        = gap_sel;
                    state_d      = GAP;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            GAP: begin
                // A zero gap still spends one cycle here.
                if (gap_q <= 2'd1) state_d = IDLE;
                else               gap_d   = gap_q - 2'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            start_q      <= 1'b0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            tag_q        <= '0;
            tmo_q        <= '0;
            gap_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_tag_q    <= '0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_q      <= start_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            tag_q        <= tag_d;
            tmo_q        <= tmo_d;
            gap_q        <= gap_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_tag_q    <= rsp_tag_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign bus.req_ready  = !fifo_full;
    assign bus.start      = start_q;
    assign bus.op         = op_q;
    assign bus.A          = a_q;
    assign bus.B          = b_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_tag    = rsp_tag_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.busy       = (state_q != IDLE) || !fifo_empty;
    assign bus.fifo_level = level;

endmodule
